// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: PC register, one fetch per cycle to a 1-cycle-latency
// instruction memory, and a DEPTH-entry prefetch FIFO drained by decode.
module if_fetch_queue #(
   parameter int              XLEN        = 16,
   parameter int              DEPTH       = 4,
   parameter int              INSTR_BYTES = 2,
   parameter logic [XLEN-1:0] RESET_PC    = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     freeze,
   input  logic                     redirect_valid,
   input  logic [1:0]               redirect_sel,
   input  logic [XLEN-1:0]          tgt_replay,
   input  logic [XLEN-1:0]          tgt_pc_imm,
   input  logic [XLEN-1:0]          tgt_regb,
   input  logic [XLEN-1:0]          tgt_rega_imm,
   output logic                     imem_req,
   output logic [XLEN-1:0]          imem_addr,
   input  logic [XLEN-1:0]          imem_rdata,
   output logic                     id_valid,
   input  logic                     id_ready,
   output logic [XLEN-1:0]          id_instr,
   output logic [XLEN-1:0]          id_pc,
   output logic [XLEN-1:0]          id_pc_next,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     pc_write
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] req_pc_q, req_pc_d;
   logic            inflight_q, inflight_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [XLEN-1:0] instr_mem_q [DEPTH];
   logic [XLEN-1:0] pc_mem_q    [DEPTH];

   logic [XLEN-1:0] redir_tgt_s;
   logic [CW:0]     occupancy_s;
   logic            issue_s;
   logic            push_s;
   logic            pop_s;

   // Redirect target select.
   always_comb begin
      redir_tgt_s = tgt_replay;
      case (redirect_sel)
         2'b00:   redir_tgt_s = tgt_replay;
         2'b01:   redir_tgt_s = tgt_pc_imm;
         2'b10:   redir_tgt_s = tgt_regb;
         2'b11:   redir_tgt_s = tgt_rega_imm;
         default: redir_tgt_s = tgt_replay;
      endcase
   end

   // Issue credit, FIFO push/pop decisions and next-state for PC and FIFO pointers.
   always_comb begin
      // Credit counts the in-flight response so a full FIFO can never be overrun.
      occupancy_s = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
      issue_s     = !rst && !redirect_valid && !freeze && (occupancy_s < (CW+1)'(DEPTH));
      push_s      = inflight_q && !redirect_valid;
      pop_s       = (count_q != '0) && id_ready && !redirect_valid;

      pc_d       = pc_q;
      req_pc_d   = req_pc_q;
      inflight_d = issue_s;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;

      if (redirect_valid) begin
         pc_d       = redir_tgt_s;
         inflight_d = 1'b0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (issue_s) begin
            pc_d     = pc_q + XLEN'(INSTR_BYTES);
            req_pc_d = pc_q;
         end else begin
            pc_d     = pc_q;
         end
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         req_pc_q   <= '0;
         inflight_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         pc_q       <= pc_d;
         req_pc_q   <= req_pc_d;
         inflight_q <= inflight_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // FIFO storage; contents are only meaningful behind a nonzero count.
   always_ff @(posedge clk) begin
      if (push_s && !rst) begin
         instr_mem_q[wr_ptr_q] <= imem_rdata;
         pc_mem_q[wr_ptr_q]    <= req_pc_q;
      end
   end

   assign imem_req   = issue_s;
   assign imem_addr  = pc_q;
   assign pc_write   = !rst && (issue_s || redirect_valid);
   assign id_valid   = (count_q != '0);
   assign id_instr   = instr_mem_q[rd_ptr_q];
   assign id_pc      = pc_mem_q[rd_ptr_q];
   assign id_pc_next = pc_mem_q[rd_ptr_q] + XLEN'(INSTR_BYTES);
   assign fifo_count = count_q;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed table-driven bench for if_fetch_queue: a main instance at RESET_PC 0
// and a second instance at RESET_PC 0xFFFC sharing its control inputs.
module tb_if_fetch_queue;

   logic        clk;
   logic        rst;
   logic        freeze;
   logic        redirect_valid;
   logic [1:0]  redirect_sel;
   logic        id_ready;
   logic [15:0] tgt_replay, tgt_pc_imm, tgt_regb, tgt_rega_imm;

   logic        imem_req,  w_imem_req;
   logic [15:0] imem_addr, w_imem_addr;
   logic [15:0] imem_rdata, w_imem_rdata;
   logic        id_valid,  w_id_valid;
   logic [15:0] id_instr,  w_id_instr;
   logic [15:0] id_pc,     w_id_pc;
   logic [15:0] id_pc_next, w_id_pc_next;
   logic [2:0]  fifo_count, w_fifo_count;
   logic        pc_write,  w_pc_write;

   int n_checks;
   int n_errors;
   int cur_row;

   if_fetch_queue #(.XLEN(16), .DEPTH(4), .INSTR_BYTES(2), .RESET_PC(16'h0000)) u_dut (
      .clk(clk), .rst(rst), .freeze(freeze),
      .redirect_valid(redirect_valid), .redirect_sel(redirect_sel),
      .tgt_replay(tgt_replay), .tgt_pc_imm(tgt_pc_imm),
      .tgt_regb(tgt_regb), .tgt_rega_imm(tgt_rega_imm),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
      .id_pc(id_pc), .id_pc_next(id_pc_next),
      .fifo_count(fifo_count), .pc_write(pc_write)
   );

   if_fetch_queue #(.XLEN(16), .DEPTH(4), .INSTR_BYTES(2), .RESET_PC(16'hFFFC)) u_wrap (
      .clk(clk), .rst(rst), .freeze(freeze),
      .redirect_valid(redirect_valid), .redirect_sel(redirect_sel),
      .tgt_replay(tgt_replay), .tgt_pc_imm(tgt_pc_imm),
      .tgt_regb(tgt_regb), .tgt_rega_imm(tgt_rega_imm),
      .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
      .id_valid(w_id_valid), .id_ready(id_ready), .id_instr(w_id_instr),
      .id_pc(w_id_pc), .id_pc_next(w_id_pc_next),
      .fifo_count(w_fifo_count), .pc_write(w_pc_write)
   );

   function automatic logic [15:0] instr_of(input logic [15:0] a);
      return a ^ 16'hC3A5;
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous-read instruction memory; junk data when no request was made.
   always @(posedge clk) begin
      imem_rdata   <= imem_req   ? instr_of(imem_addr)   : 16'hDEAD;
      w_imem_rdata <= w_imem_req ? instr_of(w_imem_addr) : 16'hDEAD;
   end

   typedef struct {
      logic        rst, frz, rv;
      logic [1:0]  sel;
      logic        rdy;
      logic        req, pw;
      logic [15:0] addr;
      logic        v;
      logic [15:0] idpc;
      logic [2:0]  cnt;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic f, input logic rv,
                               input logic [1:0] s, input logic rdy,
                               input logic req, input logic pw, input logic [15:0] addr,
                               input logic v, input logic [15:0] idpc, input logic [2:0] cnt);
      vec_t t;
      t.rst = r; t.frz = f; t.rv = rv; t.sel = s; t.rdy = rdy;
      t.req = req; t.pw = pw; t.addr = addr; t.v = v; t.idpc = idpc; t.cnt = cnt;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s row %0d: got %h expected %h", nm, cur_row, act, exp);
      end
   endtask

   vec_t tbl [53];

   initial begin
      logic [15:0] w_exp;
      n_checks = 0;
      n_errors = 0;
      cur_row  = -1;
      tgt_replay   = 16'h0300;
      tgt_pc_imm   = 16'h0200;
      tgt_regb     = 16'h0100;
      tgt_rega_imm = 16'h0400;
      rst = 1'b1; freeze = 1'b0; redirect_valid = 1'b0; redirect_sel = 2'b00; id_ready = 1'b1;

      //            rst frz rv sel  rdy  req pw addr        v  idpc      cnt
      // sequential fetch
      tbl[0]  = mk(1'b1,1'b0,1'b0,2'd0,1'b1, 1'b0,1'b0,16'h0000, 1'b0,16'h0000,3'd0);
      tbl[1]  = mk(1'b0,1'b0,1'b0,2'd0,1'b1, 1'b1,1'b1,16'h0000, 1'b0,16'h0000,3'd0);
      tbl[2]  = mk(1'b0,1'b0,1'b0,2'd0,1'b1, 1'b1,1'b1,16'h0002, 1'b0,16'h0000,3'd0);
      tbl[3]  = mk(1'b0,1'b0,1'b0,2'd0,1'b1, 1'b1,1'b1,16'h0004, 1'b1,16'h0000,3'd1);
      tbl[4]  = mk(1'b0,1'b0,1'b0,2'd0,1'b1, 1'b1,1'b1,16'h0006, 1'b1,16'h0002,3'd1);
      tbl[5]  = mk(1'b0,1'b0,1'b0,2'd0,1'b1, 1'b1,1'b1,16'h0008, 1'b1,16'h0004,3'd1);
      // backpressure from a fresh reset
      tbl[6]  = mk(1'b1,1'b0,1'b0,2'd0,1'b0, 1'b0,1'b0,16'h000A, 1'b1,16'h0006,3'd1);
      tbl[7]  = mk(1'b0,1'b0,1'b0,2'd0,1'b0, 1'b1,1'b1,16'h0000, 1'b0,16'h0000,3'd0);
      tbl[8]  = mk(1'b0,1'b0,1'b0,2'd0,1'b0, 1'b1,1'b1,16'h0002, 1'b0,16'h0000,3'd0);
      tbl[9]  = mk(1'b0,1'b0,1'b0,2'd0,1'b0, 1'b1,1'b1,16'h0004, 1'b1,16'h0000,3'd1);
      tbl[10] = mk(1'b0,1'b0,1'b0,2'd0,1'b0, 1'b1,1'b1,16'h0006, 1'b1,16'h0000,3'd2);
      tbl[11] = mk(1'b0,1'b0,1'b0,2'd0,1'b0, 1'b0,1'b0,16'h0008, 1'b1,16'h0000,3'd3);
      tbl[12] = mk(1'b0,1'b0,1'b0,2'd0,1'b0, 1'b0,1'b0,16'h0008, 1'b1,16'h0000,3'd4);
      tbl[13] = mk(1'b0,1'b0,1'b0,2'd0,1'b0, 1'b0,1'b0,16'h0008, 1'b1,16'h0000,3'd4);
      tbl[14] = mk(1'b0,1'b0,1'b0,2'd0,1'b0, 1'b0,1'b0,16'h0008, 1'b1,16'h0000,3'd4);
      tbl[15] = mk(1'b0,1'b0,1'b0,2'd0,1'b1, 1'b0,1'b0,16'h0008, 1'b1,16'h0000,3'd4);
      tbl[16] = mk(1'b0,1'b0,1'b0,2'd0,1'b1, 1'b1,1'b1,16'h0008, 1'b1,16'h0002,3'd3);
      tbl[17] = mk(1'b0,1'b0,1'b0,2'd0,1'b1, 1'b1,1'b1,16'h000A, 1'b1,16'h0004,3'd2);
      tbl[18] = mk(1'b0,1'b0,1'b0,2'd0,1'b1, 1'b1,1'b1,16'h000C, 1'b1,16'h0006,3'd2);
      tbl[19] = mk(1'b0,1'b0,1'b0,2'd0,1'b1, 1'b1,1'b1,16'h000E, 1'b1,16'h0008,3'd2);
      // redirect with 3 entries queued and a fetch in flight
      tbl[20] = mk(1'b1,1'b0,1'b0,2'd0,1'b0, 1'b0,1'b0,16'h0010, 1'b1,16'h000A,3'd2);
      tbl[21] = mk(1'b0,1'b0,1'b0,2'd0,1'b0, 1'b1,1'b1,16'h0000, 1'b0,16'h0000,3'd0);
      tbl[22] = mk(1'b0,1'b0,1'b0,2'd0,1'b0, 1'b1,1'b1,16'h0002, 1'b0,16'h0000,3'd0);
      tbl[23] = mk(1'b0,1'b0,1'b0,2'd0,1'b0, 1'b1,1'b1,16'h0004, 1'b1,16'h0000,3'd1);
      tbl[24] = mk(1'b0,1'b0,1'b0,2'd0,1'b0, 1'b1,1'b1,16'h0006, 1'b1,16'h0000,3'd2);
      tbl[25] = mk(1'b0,1'b0,1'b1,2'd2,1'b1, 1'b0,1'b1,16'h0008, 1'b1,16'h0000,3'd3);
      tbl[26] = mk(1'b0,1'b0,1'b0,2'd0,1'b1, 1'b1,1'b1,16'h0100, 1'b0,16'h0000,3'd0);
      tbl[27] = mk(1'b0,1'b0,1'b0,2'd0,1'b1, 1'b1,1'b1,16'h0102, 1'b0,16'h0000,3'd0);
      tbl[28] = mk(1'b0,1'b0,1'b0,2'd0,1'b1, 1'b1,1'b1,16'h0104, 1'b1,16'h0100,3'd1);
      tbl[29] = mk(1'b0,1'b0,1'b0,2'd0,1'b1, 1'b1,1'b1,16'h0106, 1'b1,16'h0102,3'd1);
      // freeze with a fetch in flight, then redirect during freeze
      tbl[30] = mk(1'b0,1'b1,1'b0,2'd0,1'b0, 1'b0,1'b0,16'h0108, 1'b1,16'h0104,3'd1);
      tbl[31] = mk(1'b0,1'b1,1'b0,2'd0,1'b0, 1'b0,1'b0,16'h0108, 1'b1,16'h0104,3'd2);
      tbl[32] = mk(1'b0,1'b1,1'b0,2'd0,1'b1, 1'b0,1'b0,16'h0108, 1'b1,16'h0104,3'd2);
      tbl[33] = mk(1'b0,1'b1,1'b1,2'd1,1'b0, 1'b0,1'b1,16'h0108, 1'b1,16'h0106,3'd1);
      tbl[34] = mk(1'b0,1'b1,1'b0,2'd0,1'b0, 1'b0,1'b0,16'h0200, 1'b0,16'h0000,3'd0);
      tbl[35] = mk(1'b0,1'b0,1'b0,2'd0,1'b1, 1'b1,1'b1,16'h0200, 1'b0,16'h0000,3'd0);
      tbl[36] = mk(1'b0,1'b0,1'b0,2'd0,1'b1, 1'b1,1'b1,16'h0202, 1'b0,16'h0000,3'd0);
      tbl[37] = mk(1'b0,1'b0,1'b0,2'd0,1'b1, 1'b1,1'b1,16'h0204, 1'b1,16'h0200,3'd1);
      // remaining target selects, back to back
      tbl[38] = mk(1'b0,1'b0,1'b1,2'd3,1'b1, 1'b0,1'b1,16'h0206, 1'b1,16'h0202,3'd1);
      tbl[39] = mk(1'b0,1'b0,1'b1,2'd0,1'b1, 1'b0,1'b1,16'h0400, 1'b0,16'h0000,3'd0);
      tbl[40] = mk(1'b0,1'b0,1'b0,2'd0,1'b1, 1'b1,1'b1,16'h0300, 1'b0,16'h0000,3'd0);
      tbl[41] = mk(1'b0,1'b0,1'b0,2'd0,1'b1, 1'b1,1'b1,16'h0302, 1'b0,16'h0000,3'd0);
      tbl[42] = mk(1'b0,1'b0,1'b0,2'd0,1'b1, 1'b1,1'b1,16'h0304, 1'b1,16'h0300,3'd1);
      // reset mid-operation, with a same-cycle redirect that must lose
      tbl[43] = mk(1'b1,1'b0,1'b0,2'd0,1'b0, 1'b0,1'b0,16'h0306, 1'b1,16'h0302,3'd1);
      tbl[44] = mk(1'b0,1'b0,1'b0,2'd0,1'b0, 1'b1,1'b1,16'h0000, 1'b0,16'h0000,3'd0);
      tbl[45] = mk(1'b0,1'b0,1'b0,2'd0,1'b0, 1'b1,1'b1,16'h0002, 1'b0,16'h0000,3'd0);
      tbl[46] = mk(1'b0,1'b0,1'b0,2'd0,1'b0, 1'b1,1'b1,16'h0004, 1'b1,16'h0000,3'd1);
      tbl[47] = mk(1'b0,1'b0,1'b0,2'd0,1'b0, 1'b1,1'b1,16'h0006, 1'b1,16'h0000,3'd2);
      tbl[48] = mk(1'b1,1'b0,1'b1,2'd2,1'b0, 1'b0,1'b0,16'h0008, 1'b1,16'h0000,3'd3);
      tbl[49] = mk(1'b0,1'b0,1'b0,2'd0,1'b1, 1'b1,1'b1,16'h0000, 1'b0,16'h0000,3'd0);
      tbl[50] = mk(1'b0,1'b0,1'b0,2'd0,1'b1, 1'b1,1'b1,16'h0002, 1'b0,16'h0000,3'd0);
      tbl[51] = mk(1'b0,1'b0,1'b0,2'd0,1'b1, 1'b1,1'b1,16'h0004, 1'b1,16'h0000,3'd1);
      tbl[52] = mk(1'b0,1'b0,1'b0,2'd0,1'b1, 1'b1,1'b1,16'h0006, 1'b1,16'h0002,3'd1);

      repeat (2) @(posedge clk);

      for (int i = 0; i < 53; i++) begin
         @(negedge clk);
         cur_row        = i;
         rst            = tbl[i].rst;
         freeze         = tbl[i].frz;
         redirect_valid = tbl[i].rv;
         redirect_sel   = tbl[i].sel;
         id_ready       = tbl[i].rdy;
         #1;
         chk("imem_req",   {15'd0, imem_req},   {15'd0, tbl[i].req});
         chk("pc_write",   {15'd0, pc_write},   {15'd0, tbl[i].pw});
         chk("imem_addr",  imem_addr,           tbl[i].addr);
         chk("id_valid",   {15'd0, id_valid},   {15'd0, tbl[i].v});
         chk("fifo_count", {13'd0, fifo_count}, {13'd0, tbl[i].cnt});
         if (tbl[i].v) begin
            chk("id_pc",      id_pc,      tbl[i].idpc);
            chk("id_instr",   id_instr,   instr_of(tbl[i].idpc));
            chk("id_pc_next", id_pc_next, tbl[i].idpc + 16'h0002);
         end
         // Wrap instance: reset to 0xFFFC, fetch addresses roll over to 0x0000.
         if (i >= 1 && i <= 4) begin
            w_exp = 16'hFFFC + 16'((i - 1) * 2);
            chk("wrap_addr", w_imem_addr, w_exp);
         end
         if (i == 4) begin
            chk("wrap_id_pc",      w_id_pc,      16'hFFFE);
            chk("wrap_id_pc_next", w_id_pc_next, 16'h0000);
            chk("wrap_id_instr",   w_id_instr,   instr_of(16'hFFFE));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
